// File: rtl/instr_trace_sequencer.sv
// instr_trace_sequencer: classifies committed instructions, filters them by class and serializes them into a trace FIFO.
// Entries that find no room are dropped and counted, so commit is never stalled.
module instr_trace_sequencer #(
  parameter int NrCommitPorts = 2,
  parameter int FifoDepth     = 8,
  parameter int VLEN          = 32,
  parameter int CntWidth      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          enable_i,
  input  logic [7:0]                    class_mask_i,
  input  logic [NrCommitPorts-1:0]      commit_valid_i,
  input  logic [NrCommitPorts*VLEN-1:0] commit_pc_i,
  input  logic [NrCommitPorts*32-1:0]   commit_instr_i,
  output logic                          trace_valid_o,
  input  logic                          trace_ready_i,
  output logic [VLEN-1:0]               trace_pc_o,
  output logic [31:0]                   trace_instr_o,
  output logic                          trace_compressed_o,
  output logic [2:0]                    trace_class_o,
  output logic [CntWidth-1:0]           trace_seq_o,
  output logic [$clog2(FifoDepth):0]    fifo_usage_o,
  output logic [CntWidth-1:0]           drop_cnt_o,
  output logic                          overflow_o
);
  localparam int PW = $clog2(FifoDepth);
  localparam int UW = PW + 1;
  localparam int KW = UW > 3 ? UW : 3;

  typedef struct packed {
    logic [VLEN-1:0]     pc;
    logic [31:0]         instr;
    logic                comp;
    logic [2:0]          cls;
    logic [CntWidth-1:0] seq;
  } entry_t;

  function automatic logic [2:0] classify(input logic [31:0] i);
    logic [2:0] f3;
    f3 = i[15:13];
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'b0000011, 7'b0000111:             return 3'd1;
        7'b0100011, 7'b0100111:             return 3'd2;
        7'b1100011, 7'b1101111, 7'b1100111: return 3'd3;
        7'b1110011:                         return 3'd4;
        7'b0001011:                         return 3'd5;
        7'b1011011:                         return 3'd6;
        7'b0101111:                         return 3'd7;
        default:                            return 3'd0;
      endcase
    end
    if (i[15:0] == 16'h9002) return 3'd4;
    if (i[1:0] == 2'b01) return (f3 == 3'd1 || f3 >= 3'd5) ? 3'd3 : 3'd0;
    // quadrants 00 and 10 share the load/store funct3 layout
    if (f3 inside {3'd1, 3'd2, 3'd3}) return 3'd1;
    if (f3 >= 3'd5) return 3'd2;
    return (i[1:0] == 2'b10 && f3 == 3'd4 && i[6:2] == 5'd0 && i[11:7] != 5'd0) ? 3'd3 : 3'd0;
  endfunction

  entry_t                mem [FifoDepth];
  entry_t                ent [NrCommitPorts];
  logic [PW-1:0]         rptr, wptr;
  logic [UW-1:0]         usage;
  logic [CntWidth-1:0]   seq, drop;
  logic                  ovf, pop;
  logic [2:0]            cls [NrCommitPorts];
  logic [NrCommitPorts-1:0] qual, wr;
  logic [KW-1:0]         idx [NrCommitPorts];
  logic [KW-1:0]         free, n_q, n_wr, n_drop;
  logic [CntWidth:0]     dsum;
  logic [31:0]           raw;

  always_comb begin
    free = KW'(FifoDepth) - KW'(usage);
    n_q  = '0;
    n_wr = '0;
    raw  = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      raw     = commit_instr_i[p*32 +: 32];
      cls[p]  = classify(raw);
      qual[p] = commit_valid_i[p] & enable_i & class_mask_i[cls[p]];
      idx[p]  = n_q;
      wr[p]   = qual[p] && (n_q < free);
      ent[p]  = '{pc:    commit_pc_i[p*VLEN +: VLEN],
                  instr: raw[1:0] != 2'b11 ? {16'h0, raw[15:0]} : raw,
                  comp:  raw[1:0] != 2'b11,
                  cls:   cls[p],
                  seq:   seq + CntWidth'(n_q)};
      n_q     = n_q + KW'(qual[p]);
      n_wr    = n_wr + KW'(wr[p]);
    end
    n_drop = n_q - n_wr;
    dsum   = {1'b0, drop} + (CntWidth+1)'(n_drop);
    pop    = (usage != '0) & trace_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) mem[i] <= '0;
      rptr  <= '0;
      wptr  <= '0;
      usage <= '0;
      seq   <= '0;
      drop  <= '0;
      ovf   <= 1'b0;
    end else if (flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      usage <= '0;
      seq   <= '0;
      drop  <= '0;
      ovf   <= 1'b0;
    end else begin
      for (int p = 0; p < NrCommitPorts; p++)
        if (wr[p]) mem[wptr + PW'(idx[p])] <= ent[p];
      wptr  <= wptr + PW'(n_wr);
      rptr  <= rptr + PW'(pop);
      usage <= usage + UW'(n_wr) - UW'(pop);
      seq   <= seq + CntWidth'(n_q);
      if (n_drop != '0) begin
        ovf  <= 1'b1;
        drop <= dsum[CntWidth] ? '1 : dsum[CntWidth-1:0];
      end
    end
  end

  assign trace_valid_o      = usage != '0;
  assign trace_pc_o         = mem[rptr].pc;
  assign trace_instr_o      = mem[rptr].instr;
  assign trace_compressed_o = mem[rptr].comp;
  assign trace_class_o      = mem[rptr].cls;
  assign trace_seq_o        = mem[rptr].seq;
  assign fifo_usage_o       = usage;
  assign drop_cnt_o         = drop;
  assign overflow_o         = ovf;
endmodule
